// File: rtl/switch_frame_capture_if.sv
// ============================================================================
//  Module      : switch_frame_capture_if
//  Description : Switch/button inputs and captured-frame outputs of
//                switch_frame_capture, with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface switch_frame_capture_if;
    logic       din;
    logic       shift_btn;
    logic       frame_ack;
    logic       sw1;
    logic       sw2;
    logic       sw3;
    logic       sw4;
    logic       sw5;
    logic       sw6;
    logic       sw7;
    logic       sw8;
    logic       frame_valid;
    logic [3:0] bit_count;
    logic       overrun;

    modport master (
        output din, shift_btn, frame_ack,
        input  sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8,
        input  frame_valid, bit_count, overrun
    );

    modport slave (
        input  din, shift_btn, frame_ack,
        output sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8,
        output frame_valid, bit_count, overrun
    );
endinterface

`default_nettype wire

// File: rtl/switch_frame_capture.sv
// ============================================================================
//  Module      : switch_frame_capture
//  Description : Debounced pushbutton shifts a switch bit into an 8-bit frame;
//                completed frames are presented in parallel with valid/ack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_frame_capture #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    switch_frame_capture_if.slave  bus
);

    // Counter value on the edge before it reaches DEBOUNCE_CYCLES-1.
    localparam logic [15:0] c_cnt_penult = 16'(DEBOUNCE_CYCLES - 2);
    localparam logic [15:0] c_cnt_last   = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    logic [1:0]  r_btn_sync;
    logic [1:0]  r_din_sync;
    logic        w_btn;
    logic        w_din;

    db_state_t   r_state;
    db_state_t   w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic        w_shift;

    logic [6:0]  r_partial;
    logic [7:0]  w_assembled;
    logic        w_complete;
    logic [3:0]  r_bit_count;
    logic [7:0]  r_frame;
    logic        r_valid;
    logic        r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_sync <= 2'b00;
            r_din_sync <= 2'b00;
        end else begin
            r_btn_sync <= {r_btn_sync[0], bus.shift_btn};
            r_din_sync <= {r_din_sync[0], bus.din};
        end
    end

    assign w_btn = r_btn_sync[1];
    assign w_din = r_din_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STABLE_LO;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift      = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_btn) begin
                    w_state_next = WAIT_HI;
                    w_cnt_next   = 16'd0;
                end
            end
            WAIT_HI: begin
                if (!w_btn) begin
                    w_state_next = STABLE_LO;
                end else if (r_cnt == c_cnt_penult) begin
                    w_state_next = STABLE_HI;
                    w_cnt_next   = c_cnt_last;
                    w_shift      = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + 16'd1;
                end
            end
            STABLE_HI: begin
                if (!w_btn) begin
                    w_state_next = WAIT_LO;
                    w_cnt_next   = 16'd0;
                end
            end
            WAIT_LO: begin
                if (w_btn) begin
                    w_state_next = STABLE_HI;
                end else if (r_cnt == c_cnt_penult) begin
                    w_state_next = STABLE_LO;
                    w_cnt_next   = c_cnt_last;
                end else begin
                    w_cnt_next   = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = STABLE_LO;
                w_cnt_next   = 16'd0;
            end
        endcase
    end

    // The eighth bit goes straight into the frame register, so only seven are stored.
    assign w_assembled = {r_partial, w_din};
    assign w_complete  = w_shift && (r_bit_count == 4'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_partial   <= 7'd0;
            r_bit_count <= 4'd0;
            r_frame     <= 8'd0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_shift) begin
                r_partial   <= w_assembled[6:0];
                r_bit_count <= w_complete ? 4'd0 : r_bit_count + 4'd1;
            end
            if (w_complete) begin
                r_frame <= w_assembled;
                r_valid <= 1'b1;
                if (r_valid && !bus.frame_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (bus.frame_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.sw1         = r_frame[0];
    assign bus.sw2         = r_frame[1];
    assign bus.sw3         = r_frame[2];
    assign bus.sw4         = r_frame[3];
    assign bus.sw5         = r_frame[4];
    assign bus.sw6         = r_frame[5];
    assign bus.sw7         = r_frame[6];
    assign bus.sw8         = r_frame[7];
    assign bus.frame_valid = r_valid;
    assign bus.bit_count   = r_bit_count;
    assign bus.overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_switch_frame_capture.sv
// ============================================================================
//  Module      : tb_switch_frame_capture
//  Description : Self-checking bench for switch_frame_capture (DEBOUNCE_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_frame_capture;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_bc   = 0;

    switch_frame_capture_if bus ();

    switch_frame_capture #(.DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: raw inputs delayed two cycles, level accepted after D
    // consecutive opposite samples, bits accumulated arithmetically.
    logic [1:0] m_sb, m_sd;
    logic       m_level;
    int         m_run, m_acc, m_n, m_sw;
    logic       m_valid, m_ovr;

    task automatic model_reset();
        m_sb = 2'b00; m_sd = 2'b00; m_level = 1'b0; m_run = 0;
        m_acc = 0; m_n = 0; m_sw = 0; m_valid = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic d, input logic a);
        logic sb, sd, pulse, done;
        sb = m_sb[1]; sd = m_sd[1];
        m_sb = {m_sb[0], b};
        m_sd = {m_sd[0], d};
        pulse = 1'b0; done = 1'b0;
        if (sb != m_level) begin
            m_run = m_run + 1;
            if (m_run == D) begin
                m_level = sb; m_run = 0; pulse = sb;
            end
        end else begin
            m_run = 0;
        end
        if (pulse) begin
            m_acc = ((m_acc * 2) + int'(sd)) % 256;
            m_n = m_n + 1;
            if (m_n == 8) begin m_n = 0; done = 1'b1; end
        end
        if (done) begin
            m_sw = m_acc;
            if (m_valid && !a) m_ovr = 1'b1;
            m_valid = 1'b1;
        end else if (a) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic int sw_val();
        return int'({bus.sw8, bus.sw7, bus.sw6, bus.sw5, bus.sw4, bus.sw3, bus.sw2, bus.sw1});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: apply inputs, step the model on the edge, return at the next negedge.
    task automatic cyc(input logic b, input logic d, input logic a);
        bus.shift_btn = b; bus.din = d; bus.frame_ack = a;
        @(posedge clk);
        if (!rst) model_step(b, d, a);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; model_reset(); exp_bc = 0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Clean press: the shift lands on the edge of hold cycle D+1 (2 sync + D debounce).
    task automatic press(input logic d, input logic ack_on_shift, input logic do_chk,
                         input logic vpre, input logic vpost);
        for (int i = 0; i < D + 2; i++) begin
            cyc(1'b1, d, ack_on_shift && (i == D + 1));
            if (do_chk && i == D) begin
                chk("bc_before_shift", int'(bus.bit_count), exp_bc);
                chk("valid_before_shift", int'(bus.frame_valid), int'(vpre));
            end
            if (do_chk && i == D + 1) begin
                chk("bc_after_shift", int'(bus.bit_count), (exp_bc + 1) % 8);
                chk("valid_after_shift", int'(bus.frame_valid), int'(vpost));
            end
        end
        exp_bc = (exp_bc + 1) % 8;
        for (int i = 0; i < D + 2; i++) cyc(1'b0, d, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] f, input logic ack_last);
        for (int k = 7; k >= 0; k--) press(f[k], ack_last && (k == 0), 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       do_rst;
        logic [7:0] frame;
        int         ack_mode;   // 0 none, 1 ack before frame, 2 ack on completion
        logic [7:0] exp_sw;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic       b, d, a;
        logic [7:0] bits29;
        int         len;

        vt[0] = '{1'b1, 8'hA5, 0, 8'hA5, 1'b1, 1'b0};
        vt[1] = '{1'b0, 8'h5A, 0, 8'h5A, 1'b1, 1'b1};
        vt[2] = '{1'b1, 8'h3C, 0, 8'h3C, 1'b1, 1'b0};
        vt[3] = '{1'b0, 8'hC3, 2, 8'hC3, 1'b1, 1'b0};
        vt[4] = '{1'b0, 8'hFF, 1, 8'hFF, 1'b1, 1'b0};
        vt[5] = '{1'b0, 8'h00, 0, 8'h00, 1'b1, 1'b1};
        vt[6] = '{1'b0, 8'h81, 1, 8'h81, 1'b1, 1'b1};

        bus.din = 1'b0; bus.shift_btn = 1'b0; bus.frame_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_sw", sw_val(), 0);
        chk("rst_valid", int'(bus.frame_valid), 0);
        chk("rst_bc", int'(bus.bit_count), 0);
        chk("rst_ovr", int'(bus.overrun), 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Eight clean presses, din = 1,0,1,1,0,0,1,0 first-to-last.
        bits29 = 8'b10110010;
        for (int k = 7; k >= 1; k--) press(bits29[k], 1'b0, 1'b1, 1'b0, 1'b0);
        press(bits29[0], 1'b0, 1'b1, 1'b0, 1'b1);
        chk("f29_sw", sw_val(), 'hB2);
        chk("f29_bc", int'(bus.bit_count), 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("f29_ack_clears", int'(bus.frame_valid), 0);

        // Three 2-cycle bounces then a 10-cycle hold: one shift only.
        for (int r = 0; r < 3; r++) begin
            cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < D + 2; i++) cyc(1'b0, 1'b1, 1'b0);
        exp_bc = 1;
        chk("bounce_bc", int'(bus.bit_count), 1);

        // 3-cycle glitch is rejected.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < D + 2; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("glitch_bc", int'(bus.bit_count), 1);

        // Reset after 5 bits clears everything at once; next 8 presses are a fresh frame.
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("five_bits_bc", int'(bus.bit_count), 5);
        rst = 1'b1; model_reset(); exp_bc = 0;
        #1;
        chk("midrst_sw", sw_val(), 0);
        chk("midrst_bc", int'(bus.bit_count), 0);
        chk("midrst_valid", int'(bus.frame_valid), 0);
        chk("midrst_ovr", int'(bus.overrun), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        send_frame(8'h6D, 1'b0);
        chk("fresh_sw", sw_val(), 'h6D);
        chk("fresh_valid", int'(bus.frame_valid), 1);
        chk("fresh_bc", int'(bus.bit_count), 0);

        // Button held through reset counts as a new press once debounced.
        bus.shift_btn = 1'b1;
        rst = 1'b1; model_reset(); exp_bc = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < D + 2; i++) cyc(1'b1, 1'b1, 1'b0);
        chk("held_rst_bc", int'(bus.bit_count), 1);
        for (int i = 0; i < D + 2; i++) cyc(1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 7; v++) begin
            if (vt[v].do_rst) do_reset();
            if (vt[v].ack_mode == 1) begin
                cyc(1'b0, 1'b0, 1'b1);
                chk("tbl_ack_clear", int'(bus.frame_valid), 0);
            end
            send_frame(vt[v].frame, vt[v].ack_mode == 2);
            chk("tbl_sw", sw_val(), int'(vt[v].exp_sw));
            chk("tbl_valid", int'(bus.frame_valid), int'(vt[v].exp_valid));
            chk("tbl_ovr", int'(bus.overrun), int'(vt[v].exp_ovr));
            chk("tbl_bc", int'(bus.bit_count), 0);
        end

        // Randomized bursts compared cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 4000; c = c + len) begin
            len = int'($urandom_range(1, D + 4));
            b = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                a = ($urandom_range(0, 5) == 0);
                cyc(b, d, a);
                chk("rnd_sw", sw_val(), m_sw);
                chk("rnd_valid", int'(bus.frame_valid), int'(m_valid));
                chk("rnd_bc", int'(bus.bit_count), m_n);
                chk("rnd_ovr", int'(bus.overrun), int'(m_ovr));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
